decode_writeback: RTL and testbench
===================================

DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 The block SHALL take parameter RSP_INIT, default 64'h0, as the reset value of %rsp (register 4).
REQ-002 The block SHALL have clk, input, 1, the single clock; all register writes occur on its rising edge.
REQ-003 The block SHALL have rst, input, 1, reset: asynchronous, active-high.
REQ-004 The block SHALL have instr_valid, input, 1, high when the current instruction may write back; low suppresses all writes.
REQ-005 The block SHALL have icode, input, 4, the Y86-64 instruction code.
REQ-006 The block SHALL have rA and rB, input, 4 each, register specifiers (4'hF = none).
REQ-007 The block SHALL have Cnd, input, 1, condition result from execute; gates the cmovXX write.
REQ-008 The block SHALL have valE, input, 64, execute result, and valM, input, 64, memory read data.
REQ-009 The block SHALL have valA and valB, output, 64 each, operands for execute.
REQ-010 The block SHALL have dbg_addr, input, 4, and dbg_data, output, 64, a debug read port (4'hF reads 0).

Function
REQ-011 srcA SHALL be rA for icode 2,4,6,A; 4 for icode 9,B; 4'hF otherwise.
REQ-012 srcB SHALL be rB for icode 4,5,6; 4 for icode 8,9,A,B; 4'hF otherwise.
REQ-013 dstE SHALL be rB for icode 3, 6, and icode 2 with Cnd=1; 4 for icode 8,9,A,B; 4'hF otherwise (icode 2 with Cnd=0 gives 4'hF).
REQ-014 dstM SHALL be rA for icode 5,B; 4'hF otherwise.
REQ-015 valA and valB SHALL be combinational reads of srcA/srcB; a source of 4'hF SHALL read 64'h0.
REQ-016 On a rising clk with instr_valid=1, the block SHALL write valE to dstE and valM to dstM; writes to 4'hF SHALL be discarded.
REQ-017 When dstE equals dstM and is not 4'hF (popq %rsp), only valM SHALL be written.
REQ-018 A read of a register being written in the same cycle SHALL return the old value until the edge, and the new value after it (no bypass).
REQ-019 Unrecognised icodes (C-F) and icodes 0,1,7 SHALL produce no writes and read 64'h0 on both operands.
REQ-020 With instr_valid=0, register contents SHALL remain unchanged; reads are still served.

Reset
REQ-021 While rst=1, registers 0-3 and 5-14 SHALL be 64'h0 and register 4 SHALL be RSP_INIT, taking effect immediately and independent of clk.
REQ-022 Writes presented in the same cycle that rst asserts SHALL be lost; the first write after deassertion is taken at the first rising clk with rst=0.
REQ-023 Outputs SHALL be valid combinationally from register state during reset (valA/valB/dbg_data reflect reset values).

Structure
REQ-024 A shared package y86_pkg SHALL hold the icode constants (IHALT..IPOPQ), RRSP=4'h4, RNONE=4'hF and the 64-bit word width.
REQ-025 Storage SHALL be a sub-module regfile: 15x64 entries, two async read ports, two sync write ports with M-port priority, asynchronous reset; decode/dst logic stays in decode_writeback.

Verification
REQ-026 Reset with RSP_INIT=64'h200: rst=1 -> dbg_data at addr 4 = 64'h200, addr 0 = 0, even with no clk edge.
REQ-027 irmovq (icode 3, rB=2, valE=64'd8, instr_valid=1), edge -> dbg reg 2 = 8; then opq (icode 6, rA=2, rB=2) -> valA=valB=8 before edge.
REQ-028 cmovXX (icode 2, rA=2, rB=3, valE=64'd8): Cnd=0, edge -> reg 3 unchanged (0); Cnd=1, edge -> reg 3 = 8.
REQ-029 pushq (icode A, rA=2, valE=64'h1F8), edge -> rsp = 64'h1F8; then popq rA=4 (valE=64'h200, valM=64'd55), edge -> rsp = 55 (M priority).
REQ-030 mrmovq (icode 5, rA=1, valM=64'd99) with instr_valid=0, edge -> reg 1 stays 0; repeat with instr_valid=1 -> reg 1 = 99.
REQ-031 rst asserted mid-cycle after reg 2=8 -> reg 2 reads 0 immediately; the pending write at the next edge is dropped while rst=1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, special register ids, word width.
package y86_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned NREGS  = 15;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [3:0]        reg_id_t;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam reg_id_t RRSP  = 4'h4;
  localparam reg_id_t RNONE = 4'hF;

endpackage

// File: rtl/regfile.sv
// 15 x 64-bit register file: two async operand read ports, one async debug
// read port, two sync write ports (M wins on address collision), async reset.
// Id RNONE is not storage: reads give zero, writes are dropped.
module regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   raddr_a_i,
  output logic [63:0]  rdata_a_o,
  input  logic [3:0]   raddr_b_i,
  output logic [63:0]  rdata_b_o,
  input  logic [3:0]   raddr_d_i,
  output logic [63:0]  rdata_d_o,
  input  logic         we_e_i,
  input  logic [3:0]   waddr_e_i,
  input  logic [63:0]  wdata_e_i,
  input  logic         we_m_i,
  input  logic [3:0]   waddr_m_i,
  input  logic [63:0]  wdata_m_i
);

  word_t regs_q [NREGS];
  word_t regs_d [NREGS];

  // Next register contents: E write first, then M so M overrides a shared id.
  always_comb begin
    for (int i = 0; i < int'(NREGS); i++) regs_d[i] = regs_q[i];
    if (we_e_i && (waddr_e_i != RNONE)) regs_d[waddr_e_i] = wdata_e_i;
    if (we_m_i && (waddr_m_i != RNONE)) regs_d[waddr_m_i] = wdata_m_i;
  end

  // Storage with asynchronous reset; %rsp resets to RSP_INIT, others to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++)
        regs_q[i] <= (i == int'(RRSP)) ? RSP_INIT : '0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= regs_d[i];
    end
  end

  // Unbypassed asynchronous reads straight from stored state.
  always_comb begin
    rdata_a_o = (raddr_a_i == RNONE) ? '0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == RNONE) ? '0 : regs_q[raddr_b_i];
    rdata_d_o = (raddr_d_i == RNONE) ? '0 : regs_q[raddr_d_i];
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback stage: derives source and destination register ids
// from icode, serves operand reads and commits E/M results to the regfile.
module decode_writeback
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  input  logic [3:0]   icode,
  input  logic [3:0]   rA,
  input  logic [3:0]   rB,
  input  logic         Cnd,
  input  logic [63:0]  valE,
  input  logic [63:0]  valM,
  output logic [63:0]  valA,
  output logic [63:0]  valB,
  input  logic [3:0]   dbg_addr,
  output logic [63:0]  dbg_data
);

  reg_id_t src_a, src_b, dst_e, dst_m;

  // Source/destination selection per instruction; unknown icodes touch nothing.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      IRRMOVQ: begin src_a = rA;   dst_e = Cnd ? rB : RNONE; end
      IIRMOVQ: begin               dst_e = rB;   end
      IRMMOVQ: begin src_a = rA;   src_b = rB;   end
      IMRMOVQ: begin src_b = rB;   dst_m = rA;   end
      IOPQ:    begin src_a = rA;   src_b = rB;   dst_e = rB; end
      ICALL:   begin src_b = RRSP; dst_e = RRSP; end
      IRET:    begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
      IPUSHQ:  begin src_a = rA;   src_b = RRSP; dst_e = RRSP; end
      IPOPQ:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = rA; end
      IHALT, INOP, IJXX: begin end
      default: begin end
    endcase
  end

  regfile #(.RSP_INIT(RSP_INIT)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr_a_i (src_a),
    .rdata_a_o (valA),
    .raddr_b_i (src_b),
    .rdata_b_o (valB),
    .raddr_d_i (dbg_addr),
    .rdata_d_o (dbg_data),
    .we_e_i    (instr_valid),
    .waddr_e_i (dst_e),
    .wdata_e_i (valE),
    .we_m_i    (instr_valid),
    .waddr_m_i (dst_m),
    .wdata_m_i (valM)
  );

endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: directed vector table, a mid-cycle reset
// sequence, then random instructions against a register-array model.
module tb_decode_writeback;

  localparam logic [63:0] RSP_INIT = 64'h200;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [3:0]  icode, rA, rB, dbg_addr;
  logic        Cnd;
  logic [63:0] valE, valM, valA, valB, dbg_data;

  decode_writeback #(.RSP_INIT(RSP_INIT)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .icode(icode),
    .rA(rA), .rB(rB), .Cnd(Cnd), .valE(valE), .valM(valM),
    .valA(valA), .valB(valB), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: register array plus per-icode operand role tables
  // role codes: 0 none, 1 rA, 2 rB, 3 %rsp, 4 rB only when Cnd
  logic [63:0] mdl [16];
  int role_sa [16], role_sb [16], role_de [16], role_dm [16];

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl[i] = (i == 4) ? RSP_INIT : 64'h0;
  endtask

  function automatic logic [3:0] role_id(input int role, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic c);
    case (role)
      1: return ra;
      2: return rb;
      3: return 4'h4;
      4: return c ? rb : 4'hF;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [63:0] mdl_read(input logic [3:0] id);
    return (id == 4'hF) ? 64'h0 : mdl[id];
  endfunction

  task automatic mdl_commit();
    logic [3:0] de, dm;
    de = role_id(role_de[icode], rA, rB, Cnd);
    dm = role_id(role_dm[icode], rA, rB, Cnd);
    if (instr_valid) begin
      if (de != 4'hF) mdl[de] = valE;
      if (dm != 4'hF) mdl[dm] = valM;
    end
  endtask

  // driver
  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                       input logic [3:0] rb, input logic c, input logic [63:0] e,
                       input logic [63:0] m, input logic [3:0] da);
    instr_valid = v; icode = ic; rA = ra; rB = rb; Cnd = c;
    valE = e; valM = m; dbg_addr = da;
  endtask

  typedef struct {
    logic        valid;
    logic [3:0]  icode, ra, rb;
    logic        cnd;
    logic [63:0] vale, valm;
    logic [3:0]  dbg;
    logic [63:0] exp_a, exp_b, exp_dbg;
  } vec_t;

  vec_t vecs [13];

  initial begin
    for (int i = 0; i < 16; i++) begin
      role_sa[i] = 0; role_sb[i] = 0; role_de[i] = 0; role_dm[i] = 0;
    end
    role_sa[2] = 1; role_de[2] = 4;
    role_de[3] = 2;
    role_sa[4] = 1; role_sb[4] = 2;
    role_sb[5] = 2; role_dm[5] = 1;
    role_sa[6] = 1; role_sb[6] = 2; role_de[6] = 2;
    role_sb[8] = 3; role_de[8] = 3;
    role_sa[9] = 3; role_sb[9] = 3; role_de[9] = 3;
    role_sa[10] = 1; role_sb[10] = 3; role_de[10] = 3;
    role_sa[11] = 3; role_sb[11] = 3; role_de[11] = 3; role_dm[11] = 1;

    //           valid icode  rA    rB    cnd  valE       valM     dbg   expA     expB     expDbg
    vecs[0]  = '{1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'd8,     64'd0,   4'h2, 64'd0,   64'd0,   64'd8};
    vecs[1]  = '{1'b0, 4'h6, 4'h2, 4'h2, 1'b0, 64'd1,     64'd0,   4'h2, 64'd8,   64'd8,   64'd8};
    vecs[2]  = '{1'b1, 4'h2, 4'h2, 4'h3, 1'b0, 64'd8,     64'd0,   4'h3, 64'd8,   64'd0,   64'd0};
    vecs[3]  = '{1'b1, 4'h2, 4'h2, 4'h3, 1'b1, 64'd8,     64'd0,   4'h3, 64'd8,   64'd0,   64'd8};
    vecs[4]  = '{1'b1, 4'hA, 4'h2, 4'hF, 1'b0, 64'h1F8,   64'd0,   4'h4, 64'd8,   64'h200, 64'h1F8};
    vecs[5]  = '{1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h200,   64'd55,  4'h4, 64'h1F8, 64'h1F8, 64'd55};
    vecs[6]  = '{1'b0, 4'h5, 4'h1, 4'hF, 1'b0, 64'd0,     64'd99,  4'h1, 64'd0,   64'd0,   64'd0};
    vecs[7]  = '{1'b1, 4'h5, 4'h1, 4'hF, 1'b0, 64'd0,     64'd99,  4'h1, 64'd0,   64'd0,   64'd99};
    vecs[8]  = '{1'b1, 4'hC, 4'h2, 4'h3, 1'b1, 64'd77,    64'd77,  4'h3, 64'd0,   64'd0,   64'd8};
    vecs[9]  = '{1'b1, 4'h8, 4'h2, 4'h3, 1'b0, 64'h1F0,   64'd0,   4'h4, 64'd0,   64'd55,  64'h1F0};
    vecs[10] = '{1'b1, 4'h9, 4'h2, 4'h3, 1'b0, 64'h1F8,   64'd77,  4'h4, 64'h1F0, 64'h1F0, 64'h1F8};
    vecs[11] = '{1'b1, 4'h4, 4'h2, 4'h3, 1'b1, 64'd5,     64'd6,   4'h2, 64'd8,   64'd8,   64'd8};
    vecs[12] = '{1'b1, 4'h0, 4'h2, 4'h3, 1'b1, 64'd5,     64'd6,   4'hF, 64'd0,   64'd0,   64'd0};

    // reset state, checked before any clock edge
    rst = 1'b1;
    drive(1'b0, 4'hA, 4'h4, 4'h0, 1'b0, 64'd0, 64'd0, 4'h4);
    #1;
    check("reset_rsp_dbg", dbg_data, 64'h200);
    check("reset_pushq_valA", valA, 64'h200);
    check("reset_pushq_valB", valB, 64'h200);
    dbg_addr = 4'h0;
    #1;
    check("reset_r0_dbg", dbg_data, 64'h0);

    @(negedge clk);
    rst = 1'b0;
    mdl_reset();

    // directed vector table
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].valid, vecs[i].icode, vecs[i].ra, vecs[i].rb, vecs[i].cnd,
            vecs[i].vale, vecs[i].valm, vecs[i].dbg);
      #1;
      check($sformatf("vec%0d_valA", i), valA, vecs[i].exp_a);
      check($sformatf("vec%0d_valB", i), valB, vecs[i].exp_b);
      @(posedge clk);
      mdl_commit();
      #1;
      check($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].exp_dbg);
      @(negedge clk);
    end

    // mid-cycle reset drops the pending write; first write after release lands
    drive(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'd123, 64'd0, 4'h2);
    #1;
    check("midrst_before", dbg_data, 64'd8);
    rst = 1'b1;
    #1;
    check("midrst_r2_now", dbg_data, 64'd0);
    dbg_addr = 4'h4;
    #1;
    check("midrst_rsp_now", dbg_data, 64'h200);
    dbg_addr = 4'h2;
    @(posedge clk);
    #1;
    check("midrst_edge_dropped", dbg_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    @(posedge clk);
    mdl_commit();
    #1;
    check("midrst_first_write", dbg_data, 64'd123);
    @(negedge clk);

    // random instructions against the model
    for (int n = 0; n < 400; n++) begin
      logic [3:0] ic, ra, rb, da, sa, sb;
      logic [63:0] e, m;
      ic = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      da = 4'($urandom_range(0, 15));
      e  = {$urandom, $urandom};
      m  = {$urandom, $urandom};
      drive(1'($urandom_range(0, 3) != 0), ic, ra, rb, 1'($urandom_range(0, 1)), e, m, da);
      #1;
      sa = role_id(role_sa[ic], ra, rb, Cnd);
      sb = role_id(role_sb[ic], ra, rb, Cnd);
      check($sformatf("rnd%0d_valA", n), valA, mdl_read(sa));
      check($sformatf("rnd%0d_valB", n), valB, mdl_read(sb));
      check($sformatf("rnd%0d_dbg", n), dbg_data, mdl_read(da));
      @(posedge clk);
      mdl_commit();
      @(negedge clk);
    end

    // final sweep of every register through the debug port
    instr_valid = 1'b0;
    for (int r = 0; r < 16; r++) begin
      dbg_addr = 4'(r);
      #1;
      check($sformatf("final_r%0d", r), dbg_data, mdl_read(4'(r)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
